// File: rtl/idma_desc64_pkg.sv
// Shared types for the desc64 descriptor path (fetch assembler and reshaper).
//   descriptor_t : 256-bit in-memory descriptor, little-endian beat order
//                  (length in [31:0], flags in [63:32], next, src_addr, dest_addr)
//   fetch_state_e: fetch assembler FSM states
//   Flag*        : bit positions inside descriptor_t.flags
package idma_desc64_pkg;

  localparam int unsigned DescBits = 256;

  typedef struct packed {
    logic [63:0] dest_addr;
    logic [63:0] src_addr;
    logic [63:0] next;
    logic [31:0] flags;
    logic [31:0] length;
  } descriptor_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_BEATS = 2'd2,
    ST_OUT   = 2'd3
  } fetch_state_e;

  // Flag field layout, decoded by the reshaper.
  localparam int unsigned FlagIrqBit       = 0;
  localparam int unsigned FlagBurstLsb     = 1;
  localparam int unsigned FlagBurstWidth   = 2;
  localparam int unsigned FlagCacheLsb     = 3;
  localparam int unsigned FlagCacheWidth   = 4;
  localparam int unsigned FlagProtLsb      = 7;
  localparam int unsigned FlagProtWidth    = 3;
  localparam int unsigned FlagQosLsb       = 10;
  localparam int unsigned FlagQosWidth     = 4;
  localparam int unsigned FlagSerializeBit = 14;

endpackage

// File: rtl/idma_desc64_fetch_assembler.sv
// Fetches one 256-bit descriptor with a single read burst and hands it to the
// reshaper over valid/ready. One descriptor in flight; failed fetches are
// dropped and reported with a one-cycle error pulse.
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   desc_addr_*                       descriptor address from the frontend queue
//   ar_addr_o/ar_len_o/ar_valid_o/ar_ready_i   read burst request
//   r_data_i/r_resp_i/r_last_i/r_valid_i/r_ready_o  read data beats
//   descriptor_o/descriptor_valid_o/descriptor_ready_i  assembled descriptor
//   err_valid_o/err_addr_o            fetch-error pulse with failing address
//   busy_o                            FSM not in IDLE
module idma_desc64_fetch_assembler
  import idma_desc64_pkg::*;
#(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [AddrWidth-1:0] desc_addr_i,
  input  logic                 desc_addr_valid_i,
  output logic                 desc_addr_ready_o,
  output logic [AddrWidth-1:0] ar_addr_o,
  output logic [7:0]           ar_len_o,
  output logic                 ar_valid_o,
  input  logic                 ar_ready_i,
  input  logic [DataWidth-1:0] r_data_i,
  input  logic [1:0]           r_resp_i,
  input  logic                 r_last_i,
  input  logic                 r_valid_i,
  output logic                 r_ready_o,
  output descriptor_t          descriptor_o,
  output logic                 descriptor_valid_o,
  input  logic                 descriptor_ready_i,
  output logic                 err_valid_o,
  output logic [AddrWidth-1:0] err_addr_o,
  output logic                 busy_o
);

  localparam int unsigned NumBeats = DescBits / DataWidth;
  localparam int unsigned CntW     = $clog2(NumBeats + 1);

  fetch_state_e                       r_state;
  logic [CntW-1:0]                    r_cnt;
  logic                               r_err;
  logic [NumBeats-1:0][DataWidth-1:0] r_beats;

  logic w_overrun;
  logic w_err_now;
  logic w_unused_resp;

  // Only the error bit of the response matters here.
  assign w_unused_resp = r_resp_i[0];

  // Beat arriving after the descriptor is already full.
  assign w_overrun = (r_cnt == CntW'(NumBeats));
  // Error state including the beat currently on the bus.
  assign w_err_now = r_err | r_resp_i[1] | w_overrun;

  assign ar_len_o     = 8'(NumBeats - 1);
  assign descriptor_o = descriptor_t'(r_beats);

  // Fetch FSM with registered handshake outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state            <= ST_IDLE;
      r_cnt              <= '0;
      r_err              <= 1'b0;
      r_beats            <= '0;
      desc_addr_ready_o  <= 1'b1;
      ar_addr_o          <= '0;
      ar_valid_o         <= 1'b0;
      r_ready_o          <= 1'b0;
      descriptor_valid_o <= 1'b0;
      err_valid_o        <= 1'b0;
      err_addr_o         <= '0;
      busy_o             <= 1'b0;
    end else begin
      err_valid_o <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (desc_addr_valid_i) begin
            ar_addr_o         <= desc_addr_i;
            r_cnt             <= '0;
            r_err             <= 1'b0;
            desc_addr_ready_o <= 1'b0;
            ar_valid_o        <= 1'b1;
            busy_o            <= 1'b1;
            r_state           <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (ar_ready_i) begin
            ar_valid_o <= 1'b0;
            r_ready_o  <= 1'b1;
            r_state    <= ST_BEATS;
          end
        end
        ST_BEATS: begin
          if (r_valid_i) begin
            // Pack in arrival order; overrun beats are drained but not stored.
            if (!w_overrun) begin
              for (int unsigned b = 0; b < NumBeats; b++) begin
                if (r_cnt == CntW'(b)) r_beats[b] <= r_data_i;
              end
              r_cnt <= r_cnt + CntW'(1);
            end
            r_err <= w_err_now;
            if (r_last_i) begin
              r_ready_o <= 1'b0;
              if (!w_err_now && (r_cnt == CntW'(NumBeats - 1))) begin
                descriptor_valid_o <= 1'b1;
                r_state            <= ST_OUT;
              end else begin
                err_valid_o       <= 1'b1;
                err_addr_o        <= ar_addr_o;
                desc_addr_ready_o <= 1'b1;
                busy_o            <= 1'b0;
                r_state           <= ST_IDLE;
              end
            end
          end
        end
        ST_OUT: begin
          if (descriptor_ready_i) begin
            descriptor_valid_o <= 1'b0;
            desc_addr_ready_o  <= 1'b1;
            busy_o             <= 1'b0;
            r_state            <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_idma_desc64_fetch_assembler.sv
// Directed bench for idma_desc64_fetch_assembler (AddrWidth=64, DataWidth=64).
module tb_idma_desc64_fetch_assembler;
  import idma_desc64_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [63:0] desc_addr_i;
  logic        desc_addr_valid_i;
  logic        desc_addr_ready_o;
  logic [63:0] ar_addr_o;
  logic [7:0]  ar_len_o;
  logic        ar_valid_o;
  logic        ar_ready_i;
  logic [63:0] r_data_i;
  logic [1:0]  r_resp_i;
  logic        r_last_i;
  logic        r_valid_i;
  logic        r_ready_o;
  descriptor_t descriptor_o;
  logic        descriptor_valid_o;
  logic        descriptor_ready_i;
  logic        err_valid_o;
  logic [63:0] err_addr_o;
  logic        busy_o;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  idma_desc64_fetch_assembler #(.AddrWidth(64), .DataWidth(64)) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .desc_addr_i        (desc_addr_i),
    .desc_addr_valid_i  (desc_addr_valid_i),
    .desc_addr_ready_o  (desc_addr_ready_o),
    .ar_addr_o          (ar_addr_o),
    .ar_len_o           (ar_len_o),
    .ar_valid_o         (ar_valid_o),
    .ar_ready_i         (ar_ready_i),
    .r_data_i           (r_data_i),
    .r_resp_i           (r_resp_i),
    .r_last_i           (r_last_i),
    .r_valid_i          (r_valid_i),
    .r_ready_o          (r_ready_o),
    .descriptor_o       (descriptor_o),
    .descriptor_valid_o (descriptor_valid_o),
    .descriptor_ready_i (descriptor_ready_i),
    .err_valid_o        (err_valid_o),
    .err_addr_o         (err_addr_o),
    .busy_o             (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present an address (ar_ready_i must be 1) and advance into BEATS.
  task automatic fetch(input logic [63:0] addr);
    chk("idle_addr_ready", desc_addr_ready_o, 1'b1);
    desc_addr_i       = addr;
    desc_addr_valid_i = 1'b1;
    step();
    desc_addr_valid_i = 1'b0;
    chk("ar_valid_cycle1", ar_valid_o, 1'b1);
    chk("ar_addr", ar_addr_o, addr);
    chk("ar_len", ar_len_o, 8'd3);
    chk("busy_req", busy_o, 1'b1);
    step();
    chk("r_ready_beats", r_ready_o, 1'b1);
  endtask

  task automatic beat(input logic [63:0] data, input logic [1:0] resp, input logic last);
    r_data_i  = data;
    r_resp_i  = resp;
    r_last_i  = last;
    r_valid_i = 1'b1;
    step();
    r_valid_i = 1'b0;
    r_last_i  = 1'b0;
    r_resp_i  = 2'b00;
  endtask

  task automatic accept_desc();
    descriptor_ready_i = 1'b1;
    step();
    descriptor_ready_i = 1'b0;
    chk("out_valid_drop", descriptor_valid_o, 1'b0);
    chk("out_busy_drop", busy_o, 1'b0);
  endtask

  logic [255:0] exp1;
  logic [255:0] exp2;
  logic [255:0] exp3;

  initial begin
    exp1 = {64'h0000_0000_9000_0000, 64'h0000_0000_8000_0000, 64'h0, 64'h0000_0001_0000_0100};
    exp2 = {64'h0000_0000_BBBB_0000, 64'h0000_0000_AAAA_0000, 64'h1111_2222_3333_4440,
            64'h0000_0003_0000_0040};
    exp3 = {64'h0000_0000_0000_4444, 64'h0000_0000_0000_3333, 64'h0000_0000_0000_2222,
            64'h0000_0002_0000_0011};
    rst_i = 1'b1; desc_addr_i = '0; desc_addr_valid_i = 1'b0; ar_ready_i = 1'b1;
    r_data_i = '0; r_resp_i = 2'b00; r_last_i = 1'b0; r_valid_i = 1'b0;
    descriptor_ready_i = 1'b0;
    step(); step();
    rst_i = 1'b0;
    chk("rst_ar_valid", ar_valid_o, 1'b0);
    chk("rst_r_ready", r_ready_o, 1'b0);
    chk("rst_desc_valid", descriptor_valid_o, 1'b0);
    chk("rst_err_valid", err_valid_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_desc", descriptor_o, 256'h0);
    chk("rst_ar_addr", ar_addr_o, 64'h0);
    chk("rst_err_addr", err_addr_o, 64'h0);

    // 1: nominal fetch
    fetch(64'h1000_0040);
    beat(64'h0000_0001_0000_0100, 2'b00, 1'b0);
    beat(64'h0, 2'b00, 1'b0);
    beat(64'h8000_0000, 2'b00, 1'b0);
    chk("s1_no_early_valid", descriptor_valid_o, 1'b0);
    beat(64'h9000_0000, 2'b00, 1'b1);
    chk("s1_desc_valid", descriptor_valid_o, 1'b1);
    chk("s1_desc", descriptor_o, exp1);
    chk("s1_length", descriptor_o.length, 32'h100);
    chk("s1_flags", descriptor_o.flags, 32'h1);
    chk("s1_dst", descriptor_o.dest_addr, 64'h9000_0000);
    chk("s1_r_ready_off", r_ready_o, 1'b0);
    chk("s1_no_err", err_valid_o, 1'b0);

    // 2: downstream backpressure for 10 cycles
    for (int i = 0; i < 10; i++) begin
      chk("s2_valid_held", descriptor_valid_o, 1'b1);
      chk("s2_desc_stable", descriptor_o, exp1);
      chk("s2_addr_ready_low", desc_addr_ready_o, 1'b0);
      step();
    end
    accept_desc();

    // 3: SLVERR on beat 2, all beats drained, descriptor dropped
    fetch(64'h3000_0020);
    beat(64'h1, 2'b00, 1'b0);
    beat(64'h2, 2'b10, 1'b0);
    chk("s3_still_draining", r_ready_o, 1'b1);
    chk("s3_no_err_yet", err_valid_o, 1'b0);
    beat(64'h3, 2'b00, 1'b0);
    beat(64'h4, 2'b00, 1'b1);
    chk("s3_err_pulse", err_valid_o, 1'b1);
    chk("s3_err_addr", err_addr_o, 64'h3000_0020);
    chk("s3_no_desc", descriptor_valid_o, 1'b0);
    chk("s3_busy", busy_o, 1'b0);
    step();
    chk("s3_err_one_cycle", err_valid_o, 1'b0);
    chk("s3_no_desc_later", descriptor_valid_o, 1'b0);

    // 4: early last on beat 3, then a clean fetch at 0x2000
    fetch(64'h4000_0000);
    beat(64'h5, 2'b00, 1'b0);
    beat(64'h6, 2'b00, 1'b0);
    beat(64'h7, 2'b00, 1'b1);
    chk("s4_err_pulse", err_valid_o, 1'b1);
    chk("s4_err_addr", err_addr_o, 64'h4000_0000);
    chk("s4_no_desc", descriptor_valid_o, 1'b0);
    step();
    fetch(64'h2000);
    beat(64'h0000_0003_0000_0040, 2'b00, 1'b0);
    beat(64'h1111_2222_3333_4440, 2'b00, 1'b0);
    beat(64'hAAAA_0000, 2'b00, 1'b0);
    beat(64'hBBBB_0000, 2'b00, 1'b1);
    chk("s4_valid", descriptor_valid_o, 1'b1);
    chk("s4_desc", descriptor_o, exp2);
    chk("s4_no_err", err_valid_o, 1'b0);
    accept_desc();

    // 5: AR stalled 5 cycles, R beats with random bubbles
    ar_ready_i        = 1'b0;
    desc_addr_i       = 64'h1000_0040;
    desc_addr_valid_i = 1'b1;
    step();
    desc_addr_valid_i = 1'b0;
    desc_addr_i       = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      chk("s5_ar_valid_held", ar_valid_o, 1'b1);
      chk("s5_ar_addr_stable", ar_addr_o, 64'h1000_0040);
      chk("s5_no_r_ready", r_ready_o, 1'b0);
      step();
    end
    ar_ready_i = 1'b1;
    step();
    chk("s5_ar_done", ar_valid_o, 1'b0);
    for (int b = 0; b < 4; b++) begin
      logic [255:0] w;
      int unsigned  gap;
      w   = exp1;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < int'(gap); g++) begin
        step();
        chk("s5_bubble_ready", r_ready_o, 1'b1);
      end
      beat(w[b*64 +: 64], 2'b00, (b == 3) ? 1'b1 : 1'b0);
    end
    chk("s5_valid", descriptor_valid_o, 1'b1);
    chk("s5_desc", descriptor_o, exp1);
    accept_desc();

    // 6: reset mid-BEATS after 2 beats, then a clean fetch
    fetch(64'h5000_0000);
    beat(64'hDEAD_BEEF_0000_0001, 2'b00, 1'b0);
    beat(64'hDEAD_BEEF_0000_0002, 2'b00, 1'b0);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk("s6_busy", busy_o, 1'b0);
    chk("s6_r_ready", r_ready_o, 1'b0);
    chk("s6_ar_valid", ar_valid_o, 1'b0);
    chk("s6_ar_addr", ar_addr_o, 64'h0);
    chk("s6_desc_valid", descriptor_valid_o, 1'b0);
    chk("s6_desc", descriptor_o, 256'h0);
    fetch(64'h6000_0000);
    beat(64'h0000_0002_0000_0011, 2'b00, 1'b0);
    beat(64'h2222, 2'b00, 1'b0);
    beat(64'h3333, 2'b00, 1'b0);
    beat(64'h4444, 2'b00, 1'b1);
    chk("s6_valid", descriptor_valid_o, 1'b1);
    chk("s6_clean_desc", descriptor_o, exp3);
    accept_desc();

    // 7: overrun -- fifth beat carries last; descriptor dropped
    fetch(64'h7000_0000);
    for (int b = 0; b < 4; b++) beat(64'(b + 1), 2'b00, 1'b0);
    chk("s7_draining", r_ready_o, 1'b1);
    chk("s7_no_desc", descriptor_valid_o, 1'b0);
    beat(64'h5, 2'b00, 1'b1);
    chk("s7_err_pulse", err_valid_o, 1'b1);
    chk("s7_err_addr", err_addr_o, 64'h7000_0000);
    chk("s7_no_desc_after", descriptor_valid_o, 1'b0);
    step();
    chk("s7_idle_ready", desc_addr_ready_o, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
